alu_sequencer: RTL and testbench

- Controller that sequences the team's 4-bit ALU (preprocess stage + adder) on behalf of one requester.
- Accepts commands over a valid/ready handshake, drives the ALU operand and op inputs from registers, and captures sum/carry into a result register presented over a second valid/ready handshake.
- Adds one multi-cycle command, unsigned multiply (4x4 -> 8 bit). It is done by shift-and-add, re-using the ALU's ADD operation W times.

---
 rtl/alu_sequencer_pkg.sv | 24 ++
 rtl/mul_step_reg.sv | 65 ++++++
 rtl/alu_sequencer.sv | 140 ++++++++++++++
 tb/tb_alu_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer_pkg
// Description : Shared constants for the ALU sequencer. This package holds the
//               FSM state encoding, the ALU ADD op code and the position of
//               the MUL flag inside cmd_op.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_sequencer_pkg;

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_MUL  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    // ALU op code for addition, used for every multiply step
    localparam logic [2:0] c_ADD_OP  = 3'b000;

    // When this cmd_op bit is set, the command is a MUL and bits 2:0 are ignored
    localparam int         c_MUL_BIT = 3;

endpackage
`default_nettype wire

// File: rtl/mul_step_reg.sv
`default_nettype none
// ============================================================================
// Module      : mul_step_reg
// Description : Shift-and-add multiplier state. It holds the upper product
//               half P_hi, the multiplier/lower product half Q, and the step
//               counter. Each step shifts {P_hi,Q} right by one bit. When
//               Q[0] is set, the external ALU sum (P_hi + M) is shifted in
//               instead of P_hi.
// Ports       : clk, reset (async, active-low)
//               load/load_q - clear P_hi and cnt, load Q with the multiplier
//               step        - perform one shift(-add) step
//               sum/cout    - ALU result of P_hi + M
//               p_hi        - current P_hi, fed to ALU operand A
//               p_hi_nxt/q_nxt - values after the current step
//               last        - the current step is the final one
// Revision    : 1.0 - initial release
// ============================================================================
module mul_step_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_q,
    input  logic         step,
    input  logic [W-1:0] sum,
    input  logic         cout,
    output logic [W-1:0] p_hi,
    output logic [W-1:0] p_hi_nxt,
    output logic [W-1:0] q_nxt,
    output logic         last
);

    localparam int              c_CW   = (W > 1) ? $clog2(W) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(W - 1);

    logic [W-1:0]    r_p_hi;
    logic [W-1:0]    r_q;
    logic [c_CW-1:0] r_cnt;

    // {P_hi,Q} >> 1. The bit shifted into the top of P_hi is the carry when
    // adding, and zero otherwise.
    assign p_hi_nxt = r_q[0] ? {cout, sum[W-1:1]} : {1'b0, r_p_hi[W-1:1]};
    assign q_nxt    = {(r_q[0] ? sum[0] : r_p_hi[0]), r_q[W-1:1]};
    assign p_hi     = r_p_hi;
    assign last     = (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p_hi <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
        end else if (load) begin
            r_p_hi <= '0;
            r_q    <= load_q;
            r_cnt  <= '0;
        end else if (step) begin
            r_p_hi <= p_hi_nxt;
            r_q    <= q_nxt;
            r_cnt  <= r_cnt + c_CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Sequences an external W-bit ALU for a single requester.
//               Plain ALU ops take one execute cycle. MUL (cmd_op[3]=1) is an
//               unsigned WxW->2W shift-and-add that reuses the ALU ADD for W
//               cycles. Results are held until the consumer takes them.
// Ports       : clk, reset (async, active-low)
//               cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b - command handshake
//               alu_op/alu_a/alu_b  - registered ALU inputs
//               alu_s/alu_cout      - combinational ALU result
//               res_valid/res_ready/res_data/res_cout - result handshake
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int         W      = 4,
    parameter logic [2:0] ADD_OP = c_ADD_OP
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [3:0]     cmd_op,
    input  logic [W-1:0]   cmd_a,
    input  logic [W-1:0]   cmd_b,
    output logic [2:0]     alu_op,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    input  logic [W-1:0]   alu_s,
    input  logic           alu_cout,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*W-1:0] res_data,
    output logic           res_cout
);

    logic [1:0]     r_state;
    logic [2:0]     r_alu_op;
    logic [W-1:0]   r_alu_a;
    logic [W-1:0]   r_alu_b;
    logic           r_res_valid;
    logic [2*W-1:0] r_res_data;
    logic           r_res_cout;

    logic           w_accept;
    logic           w_mul_load;
    logic [W-1:0]   w_p_hi;
    logic [W-1:0]   w_p_hi_nxt;
    logic [W-1:0]   w_q_nxt;
    logic           w_last;

    assign cmd_ready  = (r_state == c_ST_IDLE);
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_mul_load = w_accept && cmd_op[c_MUL_BIT];

    // While multiplying, operand A is the running P_hi. The multiplicand M
    // stays in the alu_b register for the whole command.
    assign alu_op    = r_alu_op;
    assign alu_a     = (r_state == c_ST_MUL) ? w_p_hi : r_alu_a;
    assign alu_b     = r_alu_b;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_cout  = r_res_cout;

    mul_step_reg #(
        .W (W)
    ) u_mul_step_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (w_mul_load),
        .load_q   (cmd_b),
        .step     (r_state == c_ST_MUL),
        .sum      (alu_s),
        .cout     (alu_cout),
        .p_hi     (w_p_hi),
        .p_hi_nxt (w_p_hi_nxt),
        .q_nxt    (w_q_nxt),
        .last     (w_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_ST_IDLE;
            r_alu_op    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_cout  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        if (cmd_op[c_MUL_BIT]) begin
                            r_alu_op <= ADD_OP;
                            r_alu_a  <= '0;
                            r_alu_b  <= cmd_a;
                            r_state  <= c_ST_MUL;
                        end else begin
                            r_alu_op <= cmd_op[2:0];
                            r_alu_a  <= cmd_a;
                            r_alu_b  <= cmd_b;
                            r_state  <= c_ST_EXEC;
                        end
                    end
                end
                c_ST_EXEC: begin
                    r_res_data  <= {{W{1'b0}}, alu_s};
                    r_res_cout  <= alu_cout;
                    r_res_valid <= 1'b1;
                    r_state     <= c_ST_DONE;
                end
                c_ST_MUL: begin
                    // Take the product from the post-step values, so the
                    // result is ready on the same edge as the final step.
                    if (w_last) begin
                        r_res_data  <= {w_p_hi_nxt, w_q_nxt};
                        r_res_cout  <= 1'b0;
                        r_res_valid <= 1'b1;
                        r_state     <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_alu_op    <= '0;
                        r_alu_a     <= '0;
                        r_alu_b     <= '0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Self-checking bench for alu_sequencer. It contains a behavioural
//               4-bit ALU (preprocess + adder) and a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    localparam int         W      = 4;
    localparam logic [2:0] ADD_OP = 3'b000;

    logic           clk;
    logic           reset;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [3:0]     cmd_op;
    logic [W-1:0]   cmd_a;
    logic [W-1:0]   cmd_b;
    logic [2:0]     alu_op;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [W-1:0]   alu_s;
    logic           alu_cout;
    logic           res_valid;
    logic           res_ready;
    logic [2*W-1:0] res_data;
    logic           res_cout;

    typedef struct packed {
        logic [2*W-1:0] data;
        logic           cout;
    } sb_item_t;

    sb_item_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    // The preprocess stage selects the adder inputs and carry-in. The adder
    // then forms x + y + cin and returns {cout, s}.
    function automatic logic [W:0] alu_ref(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] x, y;
        logic         cin;
        x = a; y = b; cin = 1'b0;
        case (op)
            3'b000: begin x = a;     y = b;      cin = 1'b0; end
            3'b001: begin x = a;     y = ~b;     cin = 1'b1; end
            3'b010: begin x = a;     y = '0;     cin = 1'b1; end
            3'b011: begin x = a;     y = '1;     cin = 1'b0; end
            3'b100: begin x = ~a;    y = b;      cin = 1'b1; end
            3'b101: begin x = a & b; y = '0;     cin = 1'b0; end
            3'b110: begin x = a | b; y = '0;     cin = 1'b0; end
            default: begin x = a ^ b; y = '0;    cin = 1'b0; end
        endcase
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
    endfunction

    assign {alu_cout, alu_s} = alu_ref(alu_op, alu_a, alu_b);

    alu_sequencer #(
        .W      (W),
        .ADD_OP (ADD_OP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_cout  (alu_cout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_cout  (res_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard consumer. A result leaves on a negedge where valid and ready
    // are both high.
    always @(negedge clk) begin
        if (reset && res_valid && res_ready) begin
            check("sb_nonempty", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                sb_item_t e;
                e = sb.pop_front();
                check("sb_res_data", res_data, e.data);
                check("sb_res_cout", res_cout, e.cout);
            end
        end
    end

    // Runs one full command. Inputs change 1 time unit after posedge, and
    // outputs are sampled on negedge.
    task automatic run_cmd(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int hold, input logic busy_valid);
        sb_item_t   e;
        logic [W:0] r;
        logic       is_mul;
        int         lat;
        int         cyc;
        is_mul = op[3];
        if (is_mul) begin
            e.data = 8'({4'b0, a} * {4'b0, b});
            e.cout = 1'b0;
            lat    = W;
        end else begin
            r      = alu_ref(op[2:0], a, b);
            e.data = {{W{1'b0}}, r[W-1:0]};
            e.cout = r[W];
            lat    = 1;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; res_ready = 1'b0;
        sb.push_back(e);
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk); #1;
        // Changes after the accept edge must not reach the DUT
        cmd_valid = 1'b0; cmd_op = 4'($urandom); cmd_a = 4'($urandom); cmd_b = 4'($urandom);
        @(negedge clk);
        check("alu_op", alu_op, is_mul ? ADD_OP : op[2:0]);
        check("alu_b", alu_b, is_mul ? a : b);
        check("alu_a", alu_a, is_mul ? 4'd0 : a);
        check("cmd_ready_busy", cmd_ready, 0);
        cyc = 0;
        while (!res_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, lat);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            cmd_valid = busy_valid; cmd_op = 4'd0; cmd_a = 4'd1; cmd_b = 4'd1;
            @(negedge clk);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_res_valid", res_valid, 1);
            check("bp_res_data", res_data, e.data);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        check("ready_cycle_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1;
        res_ready = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        check("ret_cmd_ready", cmd_ready, 1);
        check("ret_res_valid", res_valid, 0);
        check("ret_alu_clr", {alu_op, alu_a, alu_b}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_cout", res_cout, 0);
        check("rst_alu", {alu_op, alu_a, alu_b}, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        run_cmd(4'b0000, 4'd5, 4'd3, 1, 1'b0);    // 0x08, c=0
        run_cmd(4'b0000, 4'd9, 4'd9, 0, 1'b0);    // 0x02, c=1
        run_cmd(4'b1000, 4'd15, 4'd15, 0, 1'b0);  // 0xE1
        run_cmd(4'b1111, 4'd0, 4'd7, 0, 1'b0);    // 0x00, low op bits ignored
        run_cmd(4'b1000, 4'd3, 4'd5, 0, 1'b0);    // 0x0F
        run_cmd(4'b1000, 4'd6, 4'd7, 3, 1'b1);    // 0x2A under backpressure

        // Assert reset asynchronously partway through multiply step 2
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 4'b1000; cmd_a = 4'd6; cmd_b = 4'd7;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #2;
        check("pre_rst_busy", cmd_ready, 0);
        reset = 1'b0;
        #1;
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_res_data", res_data, 0);
        check("mid_rst_alu", {alu_op, alu_a, alu_b}, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        run_cmd(4'b0000, 4'd1, 4'd1, 0, 1'b0);    // 0x02

        run_cmd(4'b0001, 4'd6, 4'd2, 0, 1'b0);
        run_cmd(4'b0101, 4'd6, 4'd2, 0, 1'b0);
        run_cmd(4'b0111, 4'd6, 4'd2, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_cmd(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom),
                    int'($urandom_range(0, 2)), 1'b1);
        end

        @(posedge clk); #1;
        check("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
